// File: rtl/alu_result_fifo_pkg.sv
// Shared definitions for the ALU result FIFO.
// Flag bit map, occupancy states and the saturating-increment helper.
package alu_result_fifo_pkg;

   localparam int FLAG_W   = 4;
   localparam int FLAG_ERR = 0;
   localparam int FLAG_NEG = 1;
   localparam int FLAG_POS = 2;
   localparam int FLAG_OVF = 3;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_PARTIAL,
      OCC_FULL
   } occ_e;

   // Increment that holds at vmax instead of wrapping.
   function automatic logic [31:0] sat_inc(
      input logic [31:0] v,
      input logic [31:0] vmax
   );
      return (v >= vmax) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/alu_result_fifo_sat_counter.sv
// Saturating event counter with synchronous clear.
// A clear coincident with an event leaves the count at 1.
module sat_counter
   import alu_result_fifo_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_value
);

   localparam logic [31:0] MAX = (32'd1 << CNT_W) - 32'd1;

   logic [CNT_W-1:0] r_value;

   // Count events, saturating at all-ones; clear restarts from this event.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= CNT_W'(i_inc);
      end else if (i_inc) begin
         r_value <= CNT_W'(sat_inc(32'(r_value), MAX));
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO for ALU results and flags.
// Tracks err/ovf counts and sticky flags of every accepted entry.
module alu_result_fifo
   import alu_result_fifo_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [WIDTH-1:0]         i_result,
   input  logic [FLAG_W-1:0]        i_flag,
   input  logic                     i_drop_err,
   input  logic                     i_clr_stats,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [WIDTH-1:0]         o_result,
   output logic [FLAG_W-1:0]        o_flag,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic [CNT_W-1:0]         o_err_cnt,
   output logic [CNT_W-1:0]         o_ovf_cnt,
   output logic [FLAG_W-1:0]        o_sticky
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0]  r_mem_res [DEPTH];
   logic [FLAG_W-1:0] r_mem_flg [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [CW-1:0]     r_count;
   logic [FLAG_W-1:0] r_sticky;

   occ_e w_occ;
   logic w_ready;
   logic w_valid;
   logic w_acc;
   logic w_st;
   logic w_pop;

   // Classify occupancy from the explicit count register.
   always_comb begin
      w_occ = OCC_PARTIAL;
      if (r_count == '0) begin
         w_occ = OCC_EMPTY;
      end else if (r_count == CW'(DEPTH)) begin
         w_occ = OCC_FULL;
      end
   end

   // Ready depends only on occupancy, never on the consumer.
   assign w_ready = (w_occ != OCC_FULL);
   assign w_valid = (w_occ != OCC_EMPTY);
   assign w_acc   = i_valid & w_ready;
   assign w_st    = w_acc & ~(i_drop_err & i_flag[FLAG_ERR]);
   assign w_pop   = w_valid & i_ready;

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge i_clk) begin
      if (w_st) begin
         r_mem_res[r_wr_ptr] <= i_result;
         r_mem_flg[r_wr_ptr] <= i_flag;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_st) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         unique case ({w_st, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky OR of accepted flags; clear keeps only this cycle's event.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sticky <= '0;
      end else if (i_clr_stats) begin
         r_sticky <= w_acc ? i_flag : '0;
      end else if (w_acc) begin
         r_sticky <= r_sticky | i_flag;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clr_stats),
      .i_inc   (w_acc & i_flag[FLAG_ERR]),
      .o_value (o_err_cnt)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_ovf_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clr   (i_clr_stats),
      .i_inc   (w_acc & i_flag[FLAG_OVF]),
      .o_value (o_ovf_cnt)
   );

   assign o_ready  = w_ready;
   assign o_valid  = w_valid;
   assign o_result = w_valid ? r_mem_res[r_rd_ptr] : '0;
   assign o_flag   = w_valid ? r_mem_flg[r_rd_ptr] : '0;
   assign o_count  = r_count;
   assign o_sticky = r_sticky;

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the ALU top. It captures each ALU result and its 4-bit flag word into a small first-word-fall-through (FWFT) FIFO.
- It presents the stored entries to the consumer through a valid/ready handshake.
- It keeps saturating error and overflow counters plus sticky flags for status readout.
- Decouples ALU issue rate from a slower consumer (display/UART/register bank).

Parameters:
- WIDTH, 4, result width; equals the ALU WIDTH.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the statistics counters.

Ports:
- i_clk  input  1  clock; rising edge active.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream entry valid.
- o_ready  output  1  FIFO can accept an entry this cycle.
- i_result  input  WIDTH  ALU result.
- i_flag  input  4  ALU flags: [0] err, [1] neg, [2] pos, [3] overflow.
- i_drop_err  input  1  when 1, entries with i_flag[0]=1 are counted but not stored.
- i_clr_stats  input  1  synchronous clear of counters and sticky flags.
- o_valid  output  1  head entry valid.
- i_ready  input  1  downstream accepts the head entry.
- o_result  output  WIDTH  head result.
- o_flag  output  4  head flags, same bit map as i_flag.
- o_count  output  $clog2(DEPTH)+1  current occupancy.
- o_err_cnt  output  CNT_W  accepted entries with err=1.
- o_ovf_cnt  output  CNT_W  accepted entries with overflow=1.
- o_sticky  output  4  OR of every accepted i_flag since the last clear.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - Pointers and o_count reset to 0, so o_valid=0 and o_ready=1.
  - o_err_cnt, o_ovf_cnt and o_sticky reset to 0.
  - o_result and o_flag read 0 while the FIFO is empty.
  - Storage array contents are not reset.
- Reset mid-operation discards all stored entries immediately. The first accept after reset release is a normal write.
- Occupancy state: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
  - Tracked with wr_ptr, rd_ptr and an explicit count register.
  - Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Accept: acc = i_valid & o_ready, with o_ready = (count != DEPTH).
  - Combinational o_ready depends only on count, never on i_ready. No pass-through when FULL.
- Store: st = acc & ~(i_drop_err & i_flag[0]). A dropped entry is accepted (acc=1) but not written.
- Pop: pop = o_valid & i_ready, with o_valid = (count != 0).
- FWFT read: o_result and o_flag drive mem[rd_ptr] combinationally when o_valid=1, and 0 otherwise.
- Latency: an entry stored in cycle N is visible at the output in cycle N+1, including when the FIFO was EMPTY.
- Count update: st & ~pop gives +1; pop & ~st gives -1; st & pop gives no change, both pointers advance.
- Simultaneous events:
  - FULL with pop: o_ready=0 in that cycle, so no write. o_ready rises the next cycle.
  - EMPTY with i_valid: pop is impossible, write only.
- Statistics are updated on every acc, whether stored or dropped:
  - o_err_cnt += i_flag[0]; o_ovf_cnt += i_flag[3].
  - Both counters saturate at 2^CNT_W-1 and never wrap.
  - o_sticky |= i_flag.
- i_clr_stats has priority over the old value, but a coincident accepted event still counts.
  - Next value = event contribution, e.g. o_err_cnt=1 if the accepted entry has err=1, else 0.
  - o_sticky = i_flag if acc, else 0.
- Flag words are stored verbatim. This block never recomputes neg/pos from the result.

Decomposition:
- Shared package holds:
  - Flag bit indices: FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVF=3.
  - Flag word width constant FLAG_W=4.
  - A shared saturating-increment function.
- One natural sub-module: sat_counter (parameter CNT_W; inputs clr, inc; output value). Instantiated twice, for err and ovf.
- FIFO storage and pointer logic stay in the top module.

Test Plan:
- Reset then idle: assert i_rst mid-cycle with 2 entries held -> same cycle o_valid=0, o_ready=1, o_count=0, counters 0, o_sticky=4'b0000.
- Fill/drain, i_ready=0:
  - Write results 1,2,3,4 with flags 4'b0100 -> o_count=4, o_ready=0.
  - A 5th write with i_valid=1 is ignored.
  - Then i_ready=1 -> outputs 1,2,3,4 in order, one per cycle, then o_valid=0.
- Latency and simultaneous push/pop:
  - Empty FIFO, write 4'hA -> o_valid=1 with o_result=4'hA the next cycle, not the same cycle.
  - Streaming with i_valid=i_ready=1 holds o_count=1.
- Drop mode: i_drop_err=1, write {4'h3, 4'b0001} then {4'h5, 4'b0100} -> only 4'h5 is stored, o_err_cnt=1, o_sticky=4'b0101.
- Saturation and clear:
  - With CNT_W=2, accept 5 entries with flag 4'b1000 -> o_ovf_cnt=3, no wrap.
  - i_clr_stats coincident with an accept carrying 4'b1001 -> o_ovf_cnt=1, o_err_cnt=1, o_sticky=4'b1001.
- Pointer wrap: 10 interleaved writes/reads with DEPTH=4 and data 0..9 -> outputs 0..9 in order, no loss or duplication.
